blur_window_ctrl: RTL
=====================

# blur_window_ctrl

Streaming controller that sequences the 3x3 Gaussian blur (1-2-1 / 2-4-2 / 1-2-1, divide by 16) over a raster-order image of 4-bit pixels. It accepts one pixel per cycle over a valid/ready input, keeps two line buffers and a 3x3 window, and applies the kernel when a full window is available. Filtered interior pixels go out on a valid/ready output. It sits between the pixel source (frame memory reader) and the display/writeback path.

## Interface
Parameters:
- IMG_W, 16, pixels per row (>= 3)
- IMG_H, 16, rows per frame (>= 3)
- PIX_W, 4, pixel width in bits

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; begins a frame when idle
- in_valid  in  1  input pixel valid
- in_ready  out  1  controller accepts input pixel this cycle
- in_pix  in  PIX_W  input pixel, raster order, row 0 col 0 first
- out_valid  out  1  filtered pixel available
- out_ready  in  1  downstream accepts output pixel
- out_pix  out  PIX_W  filtered pixel
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after last output handshake

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: in_ready=0. start=1 -> RUN, row/col counters cleared, busy=1.
- RUN: input handshake = in_valid & in_ready. Each handshake shifts in_pix into the window right column, pushes the evicted line-buffer pixels up one row, advances col (wraps at IMG_W-1 to 0, row++).
- Window for input at (r,c) covers rows r-2..r, cols c-2..c; a result is produced only when r>=2 and c>=2 (center (r-1,c-1)). Border pixels produce no output; frame yields (IMG_W-2)*(IMG_H-2) outputs.
- Arithmetic: sum = p1+2p2+p3+2p4+4p5+2p6+p7+2p8+p9, SUM_W = PIX_W+4 bits (max 240 at PIX_W=4); out_pix = sum[SUM_W-1:4] (floor, no rounding, no saturation needed).
- Last input (row IMG_H-1, col IMG_W-1) accepted -> DRAIN; DRAIN waits for final output handshake -> DONE; DONE asserts done one cycle -> IDLE, busy=0.
- start while busy: ignored.
- in_valid while IDLE/DRAIN/DONE: ignored, no counter change.

## Timing
- Reset values: in_ready=0, out_valid=0, out_pix=0, busy=0, done=0, state=IDLE, counters=0. Line-buffer/window contents need no reset (never used before rows 0-1 refilled).
- in_ready = (state==RUN) & (!out_valid | out_ready): single output register; no input accepted while a result is stalled.
- Latency: out_valid rises the cycle after the handshake of the window-completing pixel; out_pix stable while out_valid & !out_ready.
- Full throughput: 1 pixel/cycle in and out when in_valid and out_ready held high.
- Simultaneous output handshake and new result: register reloads, out_valid stays 1.
- First accepted input is the cycle after start at earliest.
- done pulses the cycle after the final out handshake; next start accepted that same IDLE cycle after.
- Reset mid-frame: all state cleared immediately; partial frame discarded, no done.

## Structure
- blur_pkg: PIX_W default, SUM_W, kernel weights constants, FSM state enum.
- Sub-module blur_line_buffer: IMG_W-deep PIX_W shift register with enable; instantiated twice. Kernel sum computed inline in controller.

## Test plan
- 4x4 frame of all 15, out_ready=1 -> four outputs of 15, done one cycle after fourth, busy low afterward.
- 3x3 frame zeros with 15 at center -> one output = 3 (60>>4).
- 5x5 ramp in_pix=(r+c)%16, out_ready=1 -> nine outputs matching floor(weighted sum/16) reference model, one per cycle after fill.
- out_ready held low 5 cycles mid-frame -> out_pix held constant, in_ready=0, no pixel lost or duplicated.
- start pulsed while busy, in_valid during IDLE -> no effect; output count unchanged.
- rst_n asserted mid-frame -> all outputs 0 same cycle; fresh frame afterward produces correct results.

Source files
------------

// File: rtl/blur_pkg.sv
// Shared constants and types for the 3x3 Gaussian blur window controller.
package blur_pkg;

    // Default pixel width and the extra sum bits the kernel needs (weights add up to 16).
    localparam int PIX_W_DEF = 4;
    localparam int SUM_GUARD = 4;
    localparam int SUM_W_DEF = PIX_W_DEF + SUM_GUARD;

    // Kernel geometry and weights: 1-2-1 / 2-4-2 / 1-2-1.
    localparam int K_TAPS   = 3;
    localparam int K_CORNER = 1;
    localparam int K_EDGE   = 2;
    localparam int K_CENTER = 4;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_e;

    // Weight of window tap (row, col); index 1 is the window centre on each axis.
    function automatic int kernel_weight(input int row, input int col);
        if (row == 1 && col == 1) return K_CENTER;
        if (row == 1 || col == 1) return K_EDGE;
        return K_CORNER;
    endfunction

endpackage

// File: rtl/blur_line_buffer.sv
// One image row of delay: a DEPTH-deep shift register that advances only on en.
module blur_line_buffer
    import blur_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = PIX_W_DEF
) (
    input  logic             clk,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Shift one pixel in per enabled cycle; the tail is the pixel from one row earlier.
    // NOTE: storage is not reset -- every entry is rewritten before it is ever read.
    always_ff @(posedge clk) begin
        if (en) begin
            mem_q[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                mem_q[i] <= mem_q[i-1];
            end
        end
    end

    assign dout = mem_q[DEPTH-1];

endmodule

// File: rtl/blur_window_ctrl.sv
// Streaming 3x3 Gaussian blur controller: raster pixels in, filtered interior pixels out.
module blur_window_ctrl
    import blur_pkg::*;
#(
    parameter int IMG_W = 16,
    parameter int IMG_H = 16,
    parameter int PIX_W = PIX_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_pix,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] out_pix,
    output logic             busy,
    output logic             done
);

    localparam int SUM_W = PIX_W + SUM_GUARD;
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    state_e           state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             out_valid_q, out_valid_d;
    logic [PIX_W-1:0] out_pix_q, out_pix_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             in_hs;
    logic             out_hs;
    logic [PIX_W-1:0] lb0_out;
    logic [PIX_W-1:0] lb1_out;
    logic [PIX_W-1:0] col_a_q [K_TAPS];          // window column c-2, row 0 = oldest row
    logic [PIX_W-1:0] col_b_q [K_TAPS];          // window column c-1
    logic [PIX_W-1:0] new_col [K_TAPS];          // column c, arriving this cycle
    logic [PIX_W-1:0] win     [K_TAPS][K_TAPS];  // [row][col] of the completed window
    logic [SUM_W-1:0] kernel_sum;

    // Single output register: a stalled result blocks further input.
    assign in_ready  = (state_q == ST_RUN) && (!out_valid_q || out_ready);
    assign in_hs     = in_valid && in_ready;
    assign out_hs    = out_valid_q && out_ready;
    assign out_valid = out_valid_q;
    assign out_pix   = out_pix_q;
    assign busy      = busy_q;
    assign done      = done_q;

    // Two row delays give the pixels directly above the incoming one.
    blur_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb0 (
        .clk  (clk),
        .en   (in_hs),
        .din  (in_pix),
        .dout (lb0_out)
    );

    blur_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
        .clk  (clk),
        .en   (in_hs),
        .din  (lb0_out),
        .dout (lb1_out)
    );

    // Assemble the window including the incoming column and apply the kernel.
    always_comb begin
        new_col[0] = lb1_out;
        new_col[1] = lb0_out;
        new_col[2] = in_pix;
        kernel_sum = '0;
        for (int i = 0; i < K_TAPS; i++) begin
            win[i][0] = col_a_q[i];
            win[i][1] = col_b_q[i];
            win[i][2] = new_col[i];
            for (int j = 0; j < K_TAPS; j++) begin
                kernel_sum = kernel_sum + SUM_W'(win[i][j]) * SUM_W'(kernel_weight(i, j));
            end
        end
    end

    // Slide the window one column left on every accepted pixel.
    always_ff @(posedge clk) begin
        if (in_hs) begin
            col_a_q <= col_b_q;
            col_b_q <= new_col;
        end
    end

    // Next-state logic: frame sequencing, raster counters and the output register.
    always_comb begin
        // NOTE: every *_d gets a default first so no path leaves it unassigned (no latch).
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        out_valid_d = out_valid_q;
        out_pix_d   = out_pix_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        if (out_hs) out_valid_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    row_d   = '0;
                    col_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_RUN: begin
                if (in_hs) begin
                    // Result only once the window lies fully inside the image.
                    if (row_q >= ROW_W'(2) && col_q >= COL_W'(2)) begin
                        out_valid_d = 1'b1;
                        out_pix_d   = PIX_W'(kernel_sum >> SUM_GUARD);
                    end
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        if (row_q == ROW_LAST) begin
                            row_d   = '0;
                            state_d = ST_DRAIN;
                        end else begin
                            row_d = row_q + ROW_W'(1);
                        end
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (out_hs) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control state and registered outputs; reset discards any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            out_valid_q <= 1'b0;
            out_pix_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            out_valid_q <= out_valid_d;
            out_pix_q   <= out_pix_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

endmodule
